mux_b_t_t_n: RTL and testbench
==============================

# mux_b_t_t_n

Multi-channel temporal-select to binary multiplexer for the race-logic datapath. Each of `NUM_CHANNELS` temporal select lines is converted to a spike time within a gamma cycle. At the end of the cycle that time is matched against a shared bank of binary-coded inputs. Per channel, the block reports the matched time, a hit flag and the index of the lowest matching input. It sits between temporal column outputs and binary-domain consumers, and generalises the single-channel rising-edge mux.

## Interface
- `GAMMA_CYCLE_WIDTH`, 16: slots per gamma cycle; any value ≥ 2, not restricted to powers of two
- `NUM_INPUTS`, 16: binary inputs in the shared bank
- `NUM_CHANNELS`, 4: independent temporal select channels
- `EDGE_MODE`, `EDGE_RISING`: `EDGE_RISING` captures the first 0→1 of select; `EDGE_FALLING` captures the first 1→0
- `INPUT_WIDTH`, `$clog2(GAMMA_CYCLE_WIDTH)`: width of a time value
- `IDX_WIDTH`, `$clog2(NUM_INPUTS)` (minimum 1): width of an input index
- `aclk` in 1: clock
- `grst` in 1: synchronous, active-high reset
- `inputs` in `[NUM_INPUTS][INPUT_WIDTH]`: binary time values, shared by all channels
- `select` in `[NUM_CHANNELS]`: temporal select lines
- `out` out `[NUM_CHANNELS][INPUT_WIDTH]`: matched time; 0 when no hit
- `hit` out `[NUM_CHANNELS]`: at least one input equals the captured time
- `hit_idx` out `[NUM_CHANNELS][IDX_WIDTH]`: lowest index i with `inputs[i]` equal to the captured time; 0 when no hit
- `out_valid` out 1: one-cycle pulse marking new results
- `gamma_start` out 1: high while the counter is 0

## Operation
- Slot counter runs 0..`GAMMA_CYCLE_WIDTH`-1, then wraps to 0. It is free-running after reset.
- Edge detection:
  - Each channel registers the previous select level, `sel_q`.
  - Rising event: `select & ~sel_q`. Falling event: `~select & sel_q`.
  - `sel_q` is forced to 0 in rising mode and to 1 in falling mode on reset and at every slot 0. This means a line already high at slot 0 counts as a rising event at slot 0.
- Capture:
  - The first event in a gamma cycle stores the current counter value and sets the per-channel `captured` flag.
  - Later events in the same cycle are ignored.
  - A capture at time 0 is legal, distinguished by the `captured` flag rather than by a zero value.
- Resolve, in slot `GAMMA_CYCLE_WIDTH`-1:
  - Uses the effective capture: the stored value, or the current counter if the first event occurs in this slot.
  - Compares against all `inputs` sampled in this slot.
  - A priority encoder picks the lowest matching index.
  - Results are registered into `out`, `hit` and `hit_idx`.
- No event in the cycle: `hit`=0, `out`=0, `hit_idx`=0.
- `captured` flags clear at the start of each new cycle. A capture at slot 0 of the next cycle is still accepted.
- Outputs hold between `out_valid` pulses.
- Reset values: counter=0, all `captured`=0, `out`=0, `hit`=0, `hit_idx`=0, `out_valid`=0. `gamma_start`=1 in the first cycle after reset.

## Timing
- `out_valid` is high in the cycle after slot `GAMMA_CYCLE_WIDTH`-1, i.e. coincident with slot 0 and `gamma_start`.
- Latency is a fixed 1 cycle after the last slot, whatever the event time.
- `inputs` only need to be stable during the last slot.
- Reset mid-cycle:
  - Abandons the partial cycle: no `out_valid` for it.
  - The next full cycle starts at slot 0 in the cycle after `grst` deasserts.
- Channels are fully independent. Simultaneous events on all channels in any slot are legal.

## Structure
- Package `mux_bt_pkg` holds:
  - `edge_mode_t` enum (`EDGE_RISING`, `EDGE_FALLING`).
  - A helper function for the width of a counter of n slots.
- Sub-module `t2b_capture`, one instance per channel:
  - Performs edge detection, first-event capture and the `captured` flag.
  - Exports the effective capture value and a valid bit.
- The top level owns:
  - The slot counter.
  - The shared equality compare and priority encoder, replicated per channel.
  - The output registers.

## Test plan
- Basic rising capture (`EDGE_RISING`, G=16, N=4, C=2):
  - Stimulus: `inputs`={3,7,7,12}; ch0 rises at slot 7; ch1 rises at slot 5.
  - Required at `out_valid`: ch0 `out`=7, `hit`=1, `hit_idx`=1; ch1 `hit`=0, `out`=0, `hit_idx`=0.
- Slot-0 capture, multiple events and last-slot capture:
  - Stimulus: ch0 high before slot 0 with `inputs[2]`=0; ch0 pulses again at slot 9.
  - Required: `out`=0, `hit`=1, `hit_idx`=2; the later event is ignored.
  - Stimulus: event at slot 15 with `inputs[0]`=15.
  - Required: `hit`=1, `out`=15.
- Falling mode:
  - Stimulus: ch0 held high from slot 0, drops at slot 4; `inputs[3]`=4.
  - Required: `out`=4, `hit_idx`=3.
  - Stimulus: line never drops.
  - Required: `hit`=0.
- Non-power-of-two G=10:
  - Required: counter wraps 9→0; `out_valid` every 10 cycles.
  - Stimulus: capture at slot 9 matching `inputs`=9.
  - Required: `hit`=1.
- Reset mid-cycle:
  - Stimulus: assert `grst` at slot 6 after ch0 has captured at slot 2.
  - Required: no `out_valid` for that cycle; all outputs 0.
  - Required in the next cycle: no capture carried over, so `hit`=0 absent new events.
- Randomised: 1000 gamma cycles against a reference model, checking all outputs at every `out_valid`.

Source files
------------

// File: rtl/mux_b_t_t_n_pkg.sv
// ============================================================================
// Module      : mux_bt_pkg
// Description : Shared types and helpers for the temporal-to-binary mux.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_bt_pkg;

    typedef enum logic {
        EDGE_RISING  = 1'b0,
        EDGE_FALLING = 1'b1
    } edge_mode_t;

    // Bits needed to hold a value in 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/mux_b_t_t_n_if.sv
// ============================================================================
// Module      : mux_bt_if
// Description : Data bus of the temporal-to-binary mux (inputs, selects, results).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_bt_if
    import mux_bt_pkg::*;
#(
    parameter int NUM_INPUTS   = 16,
    parameter int NUM_CHANNELS = 4,
    parameter int INPUT_WIDTH  = 4,
    parameter int IDX_WIDTH    = cnt_width(NUM_INPUTS)
);

    logic [NUM_INPUTS-1:0][INPUT_WIDTH-1:0]   inputs;
    logic [NUM_CHANNELS-1:0]                  select;
    logic [NUM_CHANNELS-1:0][INPUT_WIDTH-1:0] out;
    logic [NUM_CHANNELS-1:0]                  hit;
    logic [NUM_CHANNELS-1:0][IDX_WIDTH-1:0]   hit_idx;
    logic                                     out_valid;
    logic                                     gamma_start;

    modport master (
        output inputs,
        output select,
        input  out,
        input  hit,
        input  hit_idx,
        input  out_valid,
        input  gamma_start
    );

    modport slave (
        input  inputs,
        input  select,
        output out,
        output hit,
        output hit_idx,
        output out_valid,
        output gamma_start
    );

endinterface

`default_nettype wire

// File: rtl/mux_b_t_t_n_t2b_capture.sv
// ============================================================================
// Module      : t2b_capture
// Description : Per-channel edge detect and first-event time capture.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module t2b_capture
    import mux_bt_pkg::*;
#(
    parameter int         INPUT_WIDTH = 4,
    parameter edge_mode_t EDGE_MODE   = EDGE_RISING
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic                   slot_zero,
    input  wire logic [INPUT_WIDTH-1:0] cnt,
    input  wire logic                   sel,
    output logic      [INPUT_WIDTH-1:0] cap_time,
    output logic                        cap_valid
);

    localparam logic c_IDLE_LEVEL = (EDGE_MODE == EDGE_FALLING);

    logic                   r_sel_q;
    logic                   r_captured;
    logic [INPUT_WIDTH-1:0] r_time;

    logic w_prev;
    logic w_event;
    logic w_captured;

    // At slot 0 the previous level is taken as idle, so a line already in
    // its active state when the cycle opens counts as an event at time 0.
    assign w_prev     = slot_zero ? c_IDLE_LEVEL : r_sel_q;
    assign w_event    = (EDGE_MODE == EDGE_FALLING) ? (~sel & w_prev) : (sel & ~w_prev);
    assign w_captured = r_captured & ~slot_zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel_q    <= c_IDLE_LEVEL;
            r_captured <= 1'b0;
            r_time     <= '0;
        end else begin
            r_sel_q    <= sel;
            r_captured <= w_captured | w_event;
            if (w_event && !w_captured) begin
                r_time <= cnt;
            end
        end
    end

    // An event in the current slot is visible immediately, which lets the
    // last slot of the cycle still resolve a capture made in that slot.
    assign cap_valid = w_captured | w_event;
    assign cap_time  = w_captured ? r_time : cnt;

endmodule

`default_nettype wire

// File: rtl/mux_b_t_t_n.sv
// ============================================================================
// Module      : mux_b_t_t_n
// Description : Multi-channel temporal-select to binary multiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_b_t_t_n
    import mux_bt_pkg::*;
#(
    parameter int         GAMMA_CYCLE_WIDTH = 16,
    parameter int         NUM_INPUTS        = 16,
    parameter int         NUM_CHANNELS      = 4,
    parameter edge_mode_t EDGE_MODE         = EDGE_RISING,
    parameter int         INPUT_WIDTH       = cnt_width(GAMMA_CYCLE_WIDTH),
    parameter int         IDX_WIDTH         = cnt_width(NUM_INPUTS)
) (
    input  wire logic aclk,
    input  wire logic grst,
    mux_bt_if.slave   bus
);

    localparam logic [INPUT_WIDTH-1:0] c_LAST_SLOT = INPUT_WIDTH'(GAMMA_CYCLE_WIDTH - 1);

    logic [INPUT_WIDTH-1:0] r_cnt;
    logic                   r_out_valid;
    logic                   w_slot_zero;
    logic                   w_last_slot;

    assign w_slot_zero = (r_cnt == '0);
    assign w_last_slot = (r_cnt == c_LAST_SLOT);

    always_ff @(posedge aclk) begin
        if (grst) begin
            r_cnt       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_cnt       <= w_last_slot ? '0 : r_cnt + 1'b1;
            r_out_valid <= w_last_slot;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.gamma_start = w_slot_zero;

    for (genvar ch = 0; ch < NUM_CHANNELS; ch++) begin : g_chan
        logic [INPUT_WIDTH-1:0] w_cap_time;
        logic                   w_cap_valid;
        logic                   w_match_any;
        logic [IDX_WIDTH-1:0]   w_match_idx;
        logic [INPUT_WIDTH-1:0] r_out;
        logic                   r_hit;
        logic [IDX_WIDTH-1:0]   r_hit_idx;

        t2b_capture #(
            .INPUT_WIDTH (INPUT_WIDTH),
            .EDGE_MODE   (EDGE_MODE)
        ) u_capture (
            .clk       (aclk),
            .rst       (grst),
            .slot_zero (w_slot_zero),
            .cnt       (r_cnt),
            .sel       (bus.select[ch]),
            .cap_time  (w_cap_time),
            .cap_valid (w_cap_valid)
        );

        // Scanning from the top down lets the lowest matching index win.
        always_comb begin
            w_match_any = 1'b0;
            w_match_idx = '0;
            for (int i = NUM_INPUTS - 1; i >= 0; i--) begin
                if (w_cap_valid && (bus.inputs[i] == w_cap_time)) begin
                    w_match_any = 1'b1;
                    w_match_idx = IDX_WIDTH'(i);
                end
            end
        end

        always_ff @(posedge aclk) begin
            if (grst) begin
                r_out     <= '0;
                r_hit     <= 1'b0;
                r_hit_idx <= '0;
            end else if (w_last_slot) begin
                r_out     <= w_match_any ? w_cap_time : '0;
                r_hit     <= w_match_any;
                r_hit_idx <= w_match_idx;
            end
        end

        assign bus.out[ch]     = r_out;
        assign bus.hit[ch]     = r_hit;
        assign bus.hit_idx[ch] = r_hit_idx;
    end

endmodule

`default_nettype wire

// File: tb/tb_mux_b_t_t_n.sv
// ============================================================================
// Module      : tb_mux_b_t_t_n
// Description : Self-checking bench for mux_b_t_t_n (rising, falling, G=10).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mux_b_t_t_n;
    import mux_bt_pkg::*;

    typedef struct packed {
        logic [1:0][3:0] out;
        logic [1:0]      hit;
        logic [1:0][1:0] idx;
    } exp_t;

    typedef struct {
        int              d;
        logic [3:0][3:0] inp;
        logic [1:0][15:0] wave;  // bit s = select level during slot s
        exp_t            e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst [3];
    logic [1:0]       sel [3];
    logic [3:0][3:0]  inp [3];
    logic [1:0][3:0]  o_out [3];
    logic [1:0]       o_hit [3];
    logic [1:0][1:0]  o_idx [3];
    logic             o_valid [3];
    logic             o_gs [3];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int last2  = -1;
    bit done   = 1'b0;

    exp_t q0[$], q1[$], q2[$];
    vec_t v[7];

    // dut0: rising G=16, dut1: falling G=16, dut2: rising G=10
    mux_bt_if #(.NUM_INPUTS(4), .NUM_CHANNELS(2), .INPUT_WIDTH(4), .IDX_WIDTH(2)) bus0 ();
    mux_bt_if #(.NUM_INPUTS(4), .NUM_CHANNELS(2), .INPUT_WIDTH(4), .IDX_WIDTH(2)) bus1 ();
    mux_bt_if #(.NUM_INPUTS(4), .NUM_CHANNELS(2), .INPUT_WIDTH(4), .IDX_WIDTH(2)) bus2 ();

    mux_b_t_t_n #(.GAMMA_CYCLE_WIDTH(16), .NUM_INPUTS(4), .NUM_CHANNELS(2), .EDGE_MODE(EDGE_RISING))
        dut0 (.aclk(clk), .grst(rst[0]), .bus(bus0.slave));
    mux_b_t_t_n #(.GAMMA_CYCLE_WIDTH(16), .NUM_INPUTS(4), .NUM_CHANNELS(2), .EDGE_MODE(EDGE_FALLING))
        dut1 (.aclk(clk), .grst(rst[1]), .bus(bus1.slave));
    mux_b_t_t_n #(.GAMMA_CYCLE_WIDTH(10), .NUM_INPUTS(4), .NUM_CHANNELS(2), .EDGE_MODE(EDGE_RISING))
        dut2 (.aclk(clk), .grst(rst[2]), .bus(bus2.slave));

    assign bus0.inputs = inp[0];  assign bus0.select = sel[0];
    assign bus1.inputs = inp[1];  assign bus1.select = sel[1];
    assign bus2.inputs = inp[2];  assign bus2.select = sel[2];
    assign o_out[0] = bus0.out;   assign o_hit[0] = bus0.hit;   assign o_idx[0] = bus0.hit_idx;
    assign o_out[1] = bus1.out;   assign o_hit[1] = bus1.hit;   assign o_idx[1] = bus1.hit_idx;
    assign o_out[2] = bus2.out;   assign o_hit[2] = bus2.hit;   assign o_idx[2] = bus2.hit_idx;
    assign o_valid[0] = bus0.out_valid;  assign o_gs[0] = bus0.gamma_start;
    assign o_valid[1] = bus1.out_valid;  assign o_gs[1] = bus1.gamma_start;
    assign o_valid[2] = bus2.out_valid;  assign o_gs[2] = bus2.gamma_start;

    task automatic chk(input string name, input int d, input int ch,
                       input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d ch%0d: got %0d, expected %0d (t=%0t)", name, d, ch, got, want, $time);
        end
    endtask

    task automatic push(input int d, input exp_t e);
        case (d)
            0:       q0.push_back(e);
            1:       q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    function automatic int qsize(input int d);
        case (d)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic exp_t pop(input int d);
        case (d)
            0:       return q0.pop_front();
            1:       return q1.pop_front();
            default: return q2.pop_front();
        endcase
    endfunction

    // Reference: scan the waveform for the first qualifying edge, then the
    // inputs for the lowest equal entry.
    function automatic exp_t model(input int g, input bit falling,
                                   input logic [3:0][3:0] vin, input logic [1:0][15:0] w);
        exp_t e;
        int   t;
        logic prev, cur;
        e = '0;
        for (int ch = 0; ch < 2; ch++) begin
            t    = -1;
            prev = falling;
            for (int s = 0; s < g; s++) begin
                cur = w[ch][s];
                if (t < 0 && (falling ? (prev && !cur) : (cur && !prev))) t = s;
                prev = cur;
            end
            if (t >= 0) begin
                for (int i = 3; i >= 0; i--) begin
                    if (vin[i] == 4'(t)) begin
                        e.hit[ch] = 1'b1;
                        e.idx[ch] = 2'(i);
                        e.out[ch] = 4'(t);
                    end
                end
            end
        end
        return e;
    endfunction

    task automatic setv(input int k, input int d,
                        input logic [3:0] i0, input logic [3:0] i1, input logic [3:0] i2, input logic [3:0] i3,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [3:0] eo0, input logic eh0, input logic [1:0] ei0,
                        input logic [3:0] eo1, input logic eh1, input logic [1:0] ei1);
        v[k].d    = d;
        v[k].inp  = {i3, i2, i1, i0};
        v[k].wave = {w1, w0};
        v[k].e.out = {eo1, eo0};
        v[k].e.hit = {eh1, eh0};
        v[k].e.idx = {ei1, ei0};
    endtask

    // Entered one time unit after the edge that opens slot 0.
    task automatic drive_cycle(input int d, input int g, input logic [3:0][3:0] vin,
                               input logic [1:0][15:0] w, input exp_t e);
        for (int s = 0; s < g; s++) begin
            inp[d] = vin;
            sel[d] = {w[1][s], w[0][s]};
            if (s == g - 1) push(d, e);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_branch(input int d, input int n_rand);
        int              g;
        bit              falling;
        int              k;
        logic [3:0][3:0] vin;
        logic [1:0][15:0] w;
        exp_t            e;
        g       = (d == 2) ? 10 : 16;
        falling = (d == 1);

        for (int j = 0; j < 7; j++) begin
            if (v[j].d == d) drive_cycle(d, g, v[j].inp, v[j].wave, v[j].e);
        end

        if (d == 0) begin
            // Capture at slot 2, then reset at slot 6 abandons the cycle.
            for (int s = 0; s < 6; s++) begin
                inp[0] = {4'd2, 4'd2, 4'd2, 4'd2};
                sel[0] = {1'b0, (s >= 2)};
                @(posedge clk);
                #1;
            end
            rst[0] = 1'b1;
            sel[0] = 2'b11;
            @(posedge clk);
            repeat (2) begin
                @(negedge clk);
                chk("midrst_valid", 0, 0, o_valid[0], 0);
                chk("midrst_hit",   0, 0, o_hit[0], 0);
                chk("midrst_out",   0, 0, o_out[0], 0);
                chk("midrst_idx",   0, 0, o_idx[0], 0);
                @(posedge clk);
            end
            #1;
            rst[0] = 1'b0;
            drive_cycle(0, 16, {4'd2, 4'd2, 4'd2, 4'd2}, '0, '0);
        end

        for (int n = 0; n < n_rand; n++) begin
            k = 0;
            for (int ch = 0; ch < 2; ch++) begin
                k = $urandom_range(0, g - 1);
                case ($urandom_range(0, 2))
                    0:       w[ch] = 16'($urandom);
                    1:       w[ch] = falling ? ~(16'hFFFF << k) : (16'hFFFF << k);
                    default: w[ch] = falling ? 16'hFFFF : 16'h0000;
                endcase
            end
            for (int i = 0; i < 4; i++) begin
                vin[i] = ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, g - 1));
            end
            if ($urandom_range(0, 1) == 1) vin[$urandom_range(0, 3)] = 4'(k);
            e = model(g, falling, vin, w);
            drive_cycle(d, g, vin, w, e);
        end
        // Park the DUT so it raises no further out_valid.
        rst[d] = 1'b1;
    endtask

    initial begin
        exp_t e;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1;
            sel[d] = '0;
            inp[d] = '0;
        end
        setv(0, 0, 4'd3, 4'd7, 4'd7, 4'd12, 16'hFF80, 16'hFFE0, 4'd7, 1'b1, 2'd1, 4'd0, 1'b0, 2'd0);
        setv(1, 0, 4'd5, 4'd6, 4'd0, 4'd9,  16'h0207, 16'h0000, 4'd0, 1'b1, 2'd2, 4'd0, 1'b0, 2'd0);
        setv(2, 0, 4'd15, 4'd3, 4'd0, 4'd15, 16'h8000, 16'hFFFF, 4'd15, 1'b1, 2'd0, 4'd0, 1'b1, 2'd2);
        setv(3, 1, 4'd1, 4'd2, 4'd3, 4'd4,  16'h000F, 16'hFFFF, 4'd4, 1'b1, 2'd3, 4'd0, 1'b0, 2'd0);
        setv(4, 1, 4'd9, 4'd0, 4'd15, 4'd1, 16'h0000, 16'h7FFF, 4'd0, 1'b1, 2'd1, 4'd15, 1'b1, 2'd2);
        setv(5, 2, 4'd9, 4'd2, 4'd9, 4'd4,  16'hFE00, 16'h0044, 4'd9, 1'b1, 2'd0, 4'd2, 1'b1, 2'd1);
        setv(6, 2, 4'd12, 4'd13, 4'd0, 4'd0, 16'h0000, 16'hFFFF, 4'd0, 1'b0, 2'd0, 4'd0, 1'b1, 2'd2);

        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk("reset_valid", d, 0, o_valid[d], 0);
            chk("reset_gamma_start", d, 0, o_gs[d], 1);
            for (int ch = 0; ch < 2; ch++) begin
                chk("reset_out", d, ch, o_out[d][ch], 0);
                chk("reset_hit", d, ch, o_hit[d][ch], 0);
                chk("reset_idx", d, ch, o_idx[d][ch], 0);
            end
        end
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;

        fork
            begin
                fork
                    run_branch(0, 400);
                    run_branch(1, 300);
                    run_branch(2, 300);
                join
                repeat (2) @(negedge clk);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    cyc++;
                    for (int d = 0; d < 3; d++) begin
                        if (o_valid[d] === 1'b1) begin
                            if (qsize(d) == 0) begin
                                chk("unexpected_out_valid", d, 0, o_valid[d], 0);
                            end else begin
                                e = pop(d);
                                chk("gamma_start_at_valid", d, 0, o_gs[d], 1);
                                for (int ch = 0; ch < 2; ch++) begin
                                    chk("out",     d, ch, o_out[d][ch], e.out[ch]);
                                    chk("hit",     d, ch, o_hit[d][ch], e.hit[ch]);
                                    chk("hit_idx", d, ch, o_idx[d][ch], e.idx[ch]);
                                end
                            end
                            if (d == 2) begin
                                if (last2 >= 0) chk("valid_period_g10", 2, 0, cyc - last2, 10);
                                last2 = cyc;
                            end
                        end
                    end
                end
            end
        join

        for (int d = 0; d < 3; d++) chk("missing_out_valid", d, 0, qsize(d), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
